// File: rtl/apb_pkg.sv
// Shared APB3 definitions for the tank fabric: requester states, default bus
// widths and the register offsets of the existing APB3 peripherals.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  // Peripheral register offsets
  localparam logic [APB_ADDR_W-1:0] OFS_MOTOR_DIR = 32'h0000_0004;
  localparam logic [APB_ADDR_W-1:0] OFS_MOTOR_PWM = 32'h0000_0008;
  localparam logic [APB_ADDR_W-1:0] OFS_SERVO1    = 32'h0000_0010;
  localparam logic [APB_ADDR_W-1:0] OFS_SERVO2    = 32'h0000_0014;
  localparam logic [APB_ADDR_W-1:0] OFS_IR_FREQ   = 32'h0000_0020;
  localparam logic [APB_ADDR_W-1:0] OFS_HITS      = 32'h0000_0024;

  // Increment that sticks at 255 instead of wrapping
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/apb3_requester.sv
// APB3 initiator: accepts one command at a time from the fabric controller,
// runs the SETUP/ACCESS handshake toward the peripherals and hands back the
// result on a ready/valid response port. One transfer in flight at most.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | cmd_ready high, bus idle; PADDR/PWRITE/PWDATA keep last values
// SETUP  | PSEL high for one cycle, timeout counter cleared
// ACCESS | PSEL+PENABLE high, waiting for PREADY or timeout
// RESP   | bus idle, rsp_valid high with stable fields until rsp_ready
module apb3_requester
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESERN,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [7:0]        err_cnt,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  // Counter must hold the value TIMEOUT; keep at least one bit when disabled.
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT);

  apb_state_e        state_q;
  logic              cmd_ready_q;
  logic              rsp_valid_q;
  logic              psel_q;
  logic              penable_q;
  logic              pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;
  logic              rsp_timeout_q;
  logic [7:0]        err_cnt_q;
  logic [CNT_W-1:0]  to_cnt_q;
  logic [CNT_W-1:0]  to_cnt_d;
  logic              to_hit;

  // Count of stalled ACCESS cycles including this one, and whether it expires now
  always_comb begin
    to_cnt_d = to_cnt_q + CNT_W'(1);
    to_hit   = (TIMEOUT != 0) && (to_cnt_d == TO_LIMIT);
  end

  // Transfer sequencer with registered bus/response outputs and error counter
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      state_q       <= IDLE;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      err_cnt_q     <= 8'd0;
      to_cnt_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            pwrite_q    <= cmd_write;
            paddr_q     <= cmd_addr;
            pwdata_q    <= cmd_wdata;
            psel_q      <= 1'b1;
            cmd_ready_q <= 1'b0;
            state_q     <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          to_cnt_q  <= '0;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          // PREADY is checked first so a completion on the expiry edge wins
          if (PREADY) begin
            rsp_rdata_q   <= (pwrite_q || PSLVERR) ? '0 : PRDATA;
            rsp_err_q     <= PSLVERR;
            rsp_timeout_q <= 1'b0;
            if (PSLVERR) begin
              err_cnt_q <= sat_inc8(err_cnt_q);
            end
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else if (to_hit) begin
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            err_cnt_q     <= sat_inc8(err_cnt_q);
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            state_q       <= RESP;
          end else if (TIMEOUT != 0) begin
            to_cnt_q <= to_cnt_d;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign err_cnt     = err_cnt_q;
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;

endmodule
